// File: rtl/branch_target_table.sv
// Multi-bank branch-target lookup: jump index -> absolute PC target, with per-entry
// valid bits, a registered hit/miss read port, and a sweep FSM that clears storage.
module branch_target_table #(
    parameter int ADDR_W = 4,
    parameter int TGT_W  = 8,
    parameter int BANKS  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      bank_ld_i,
    input  logic [$clog2(BANKS)-1:0]  bank_sel_i,
    input  logic                      rd_en_i,
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic                      wr_en_i,
    input  logic [$clog2(BANKS)-1:0]  wr_bank_i,
    input  logic [ADDR_W-1:0]         wr_addr_i,
    input  logic [TGT_W-1:0]          wr_data_i,
    input  logic                      clr_req_i,
    input  logic [$clog2(BANKS)-1:0]  clr_bank_i,
    output logic [TGT_W-1:0]          target_o,
    output logic                      hit_o,
    output logic                      rd_valid_o,
    output logic                      busy_o,
    output logic                      wr_drop_o
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int BANK_W  = $clog2(BANKS);
    localparam int IDX_W   = BANK_W + ADDR_W;
    localparam int ENTRIES = BANKS * DEPTH;

    typedef enum logic [1:0] {SWEEP_ALL, SWEEP_BANK, IDLE} state_t;

    // Each word is {valid, target}.
    logic [TGT_W:0] mem [ENTRIES];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  sweep_q, sweep_d;
    logic [BANK_W-1:0] clr_bank_q, clr_bank_d;
    logic [BANK_W-1:0] active_q;
    logic [TGT_W-1:0]  target_q;
    logic              hit_q, rd_valid_q, wr_drop_q;

    logic              idle, wr_ok, rd_ok, fwd, mem_we;
    logic [IDX_W-1:0]  rd_idx, wr_idx, mem_waddr;
    logic [TGT_W:0]    mem_wdata, rd_word;

    assign idle   = (state_q == IDLE);
    assign rd_idx = {active_q, addr_i};
    assign wr_idx = {wr_bank_i, wr_addr_i};
    // A clear issued in the same cycle as a write takes priority and kills the write.
    assign wr_ok  = idle && wr_en_i && !clr_req_i;
    assign rd_ok  = idle && rd_en_i;
    assign fwd    = wr_ok && (wr_idx == rd_idx);

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        clr_bank_d = clr_bank_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_idx;
        mem_wdata  = {1'b1, wr_data_i};
        case (state_q)
            SWEEP_ALL: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                mem_wdata = '0;
                sweep_d   = sweep_q + IDX_W'(1);
                if (sweep_q == IDX_W'(ENTRIES - 1)) begin
                    state_d = IDLE;
                    sweep_d = '0;
                end
            end
            SWEEP_BANK: begin
                mem_we    = 1'b1;
                mem_waddr = {clr_bank_q, sweep_q[ADDR_W-1:0]};
                mem_wdata = '0;
                sweep_d   = sweep_q + IDX_W'(1);
                if (sweep_q[ADDR_W-1:0] == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                    sweep_d = '0;
                end
            end
            IDLE: begin
                if (clr_req_i) begin
                    state_d    = SWEEP_BANK;
                    sweep_d    = '0;
                    clr_bank_d = clr_bank_i;
                end else if (wr_en_i) begin
                    mem_we = 1'b1;
                end
            end
            default: begin
                state_d = SWEEP_ALL;
                sweep_d = '0;
            end
        endcase
    end

    // Storage has no reset; the post-reset sweep is what invalidates it.
    always_ff @(posedge clk_i) begin
        if (mem_we && rst_ni) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_word = mem[rd_idx];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= SWEEP_ALL;
            sweep_q    <= '0;
            clr_bank_q <= '0;
            active_q   <= '0;
            target_q   <= '0;
            hit_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            clr_bank_q <= clr_bank_d;
            rd_valid_q <= rd_ok;
            wr_drop_q  <= (!idle && (wr_en_i || clr_req_i)) || (idle && clr_req_i && wr_en_i);
            if (bank_ld_i) begin
                active_q <= bank_sel_i;
            end
            if (rd_ok) begin
                if (fwd) begin
                    target_q <= wr_data_i;
                    hit_q    <= 1'b1;
                end else begin
                    target_q <= rd_word[TGT_W] ? rd_word[TGT_W-1:0] : '0;
                    hit_q    <= rd_word[TGT_W];
                end
            end
        end
    end

    assign target_o   = target_q;
    assign hit_o      = hit_q;
    assign rd_valid_o = rd_valid_q;
    assign wr_drop_o  = wr_drop_q;
    assign busy_o     = !idle;
endmodule

// File: tb/tb_branch_target_table.sv
// Bench for branch_target_table: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the table.
module tb_branch_target_table;
    localparam int ADDR_W = 4, TGT_W = 8, BANKS = 4;
    localparam int DEPTH = 1 << ADDR_W, BANK_W = $clog2(BANKS), ENTRIES = BANKS * DEPTH;

    logic clk = 1'b0, rst_n = 1'b0;
    logic bank_ld, rd_en, wr_en, clr_req;
    logic [BANK_W-1:0] bank_sel, wr_bank, clr_bank;
    logic [ADDR_W-1:0] addr, wr_addr;
    logic [TGT_W-1:0] wr_data, target;
    logic hit, rd_valid, busy, wr_drop;

    always #5 clk = ~clk;

    branch_target_table #(.ADDR_W(ADDR_W), .TGT_W(TGT_W), .BANKS(BANKS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bank_ld_i(bank_ld), .bank_sel_i(bank_sel),
        .rd_en_i(rd_en), .addr_i(addr), .wr_en_i(wr_en), .wr_bank_i(wr_bank),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .clr_req_i(clr_req),
        .clr_bank_i(clr_bank), .target_o(target), .hit_o(hit), .rd_valid_o(rd_valid),
        .busy_o(busy), .wr_drop_o(wr_drop)
    );

    // Reference model: contents, active bank, remaining busy cycles, expected outputs.
    bit m_valid [ENTRIES];
    int m_data [ENTRIES];
    int m_active, m_busy_left, e_target, e_hit, e_rdv, e_drop;
    int total = 0, bad = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int ri;
        if (!rst_n) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_busy_left = ENTRIES; m_active = 0;
            e_target = 0; e_hit = 0; e_rdv = 0; e_drop = 0;
            return;
        end
        e_rdv = 0; e_drop = 0;
        if (m_busy_left > 0) begin
            if (wr_en || clr_req) e_drop = 1;
            m_busy_left--;
        end else begin
            if (clr_req && wr_en) e_drop = 1;
            if (wr_en && !clr_req) begin
                m_valid[int'(wr_bank) * DEPTH + int'(wr_addr)] = 1'b1;
                m_data[int'(wr_bank) * DEPTH + int'(wr_addr)] = int'(wr_data);
            end
            if (rd_en) begin
                ri = m_active * DEPTH + int'(addr);
                e_rdv = 1;
                e_hit = m_valid[ri] ? 1 : 0;
                e_target = m_valid[ri] ? m_data[ri] : 0;
            end
            if (clr_req) begin
                for (int a = 0; a < DEPTH; a++) m_valid[int'(clr_bank) * DEPTH + a] = 1'b0;
                m_busy_left = DEPTH;
            end
        end
        if (bank_ld) m_active = int'(bank_sel);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_eq("busy", int'(busy), (m_busy_left > 0) ? 1 : 0);
        check_eq("rd_valid", int'(rd_valid), e_rdv);
        check_eq("wr_drop", int'(wr_drop), e_drop);
        check_eq("target", int'(target), e_target);
        check_eq("hit", int'(hit), e_hit);
        if (rd_valid || wr_drop)
            $display("t=%0t rdv=%0b tgt=%0d hit=%0b drop=%0b busy=%0b", $time, rd_valid, target, hit, wr_drop, busy);
    endtask

    task automatic idle_in();
        bank_ld = 0; bank_sel = '0; rd_en = 0; addr = '0; wr_en = 0; wr_bank = '0;
        wr_addr = '0; wr_data = '0; clr_req = 0; clr_bank = '0;
    endtask

    task automatic do_write(input int b, input int a, input int d);
        idle_in(); wr_en = 1; wr_bank = BANK_W'(b); wr_addr = ADDR_W'(a); wr_data = TGT_W'(d);
        step(); idle_in();
    endtask

    task automatic do_read(input int a);
        idle_in(); rd_en = 1; addr = ADDR_W'(a);
        step(); idle_in();
    endtask

    task automatic do_bank(input int b);
        idle_in(); bank_ld = 1; bank_sel = BANK_W'(b);
        step(); idle_in();
    endtask

    task automatic wait_idle(input string tag, input int exp_cycles);
        int cnt = 0;
        while (busy && cnt < 200) begin step(); cnt++; end
        check_eq(tag, cnt, exp_cycles);
    endtask

    initial begin
        int cnt, saw_drop;
        idle_in();
        rst_n = 0;
        step(); step();
        rst_n = 1;
        wait_idle("reset_sweep_len", ENTRIES);

        do_read(5);
        check_eq("post_reset_rdv", int'(rd_valid), 1);
        check_eq("post_reset_hit", int'(hit), 0);
        check_eq("post_reset_tgt", int'(target), 0);

        do_write(0, 2, 235); do_write(0, 3, 210);
        do_read(2); check_eq("rd_idx2", int'(target), 235); check_eq("rd_idx2_hit", int'(hit), 1);
        do_read(3); check_eq("rd_idx3", int'(target), 210); check_eq("rd_idx3_hit", int'(hit), 1);

        do_write(1, 0, 6); do_write(1, 8, 131);
        idle_in(); bank_ld = 1; bank_sel = 1; rd_en = 1; addr = 8;
        step(); idle_in();
        check_eq("bankld_old_bank_hit", int'(hit), 0);
        do_read(8); check_eq("new_bank_tgt", int'(target), 131); check_eq("new_bank_hit", int'(hit), 1);

        do_bank(0);
        idle_in(); rd_en = 1; addr = 4; wr_en = 1; wr_bank = 0; wr_addr = 4; wr_data = 227;
        step(); idle_in();
        check_eq("fwd_tgt", int'(target), 227); check_eq("fwd_hit", int'(hit), 1);

        for (int i = 0; i < 2 * DEPTH; i++) do_write(i / DEPTH, i % DEPTH, 1 + $urandom_range(0, 254));
        idle_in(); clr_req = 1; clr_bank = 0;
        step(); idle_in();
        cnt = 0; saw_drop = 0;
        while (busy && cnt < 200) begin
            wr_en = (cnt == 3); wr_bank = 1; wr_addr = 1; wr_data = 99;
            step(); idle_in();
            if (wr_drop) saw_drop = 1;
            cnt++;
        end
        check_eq("bank_clear_len", cnt, DEPTH);
        check_eq("bank_clear_drop", saw_drop, 1);
        for (int a = 0; a < DEPTH; a++) begin do_read(a); check_eq("cleared_miss", int'(hit), 0); end
        do_bank(1);
        for (int a = 0; a < DEPTH; a++) begin do_read(a); check_eq("kept_hit", int'(hit), 1); end

        do_bank(0);
        idle_in(); clr_req = 1; clr_bank = 2;
        step(); idle_in();
        for (int i = 1; i < 30; i++) step();
        rst_n = 0;
        step();
        check_eq("midreset_tgt", int'(target), 0); check_eq("midreset_hit", int'(hit), 0);
        check_eq("midreset_busy", int'(busy), 1);
        rst_n = 1;
        wait_idle("midreset_sweep_len", ENTRIES);
        for (int b = 0; b < 2; b++) begin
            do_bank(b);
            for (int a = 0; a < DEPTH; a++) begin do_read(a); check_eq("after_reset_miss", int'(hit), 0); end
        end

        for (int n = 0; n < 3000; n++) begin
            rst_n    = ($urandom_range(0, 999) != 0);
            bank_ld  = ($urandom_range(0, 7) == 0);
            bank_sel = BANK_W'($urandom);
            rd_en    = ($urandom_range(0, 1) == 0);
            addr     = ADDR_W'($urandom);
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_bank  = BANK_W'($urandom);
            wr_addr  = ADDR_W'($urandom);
            wr_data  = TGT_W'($urandom);
            clr_req  = ($urandom_range(0, 59) == 0);
            clr_bank = BANK_W'($urandom);
            step();
        end
        rst_n = 1; idle_in();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
